// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
// Central stall/flush sequencer for the in-order pipeline. It generates the
// load enables and clears for the ID, EXE, MEM0 and MEM1 pipeline registers.
// It also owns the front-end redirect handshake for precise MEM0 events
// (exception, eret, refetch) and the sequencing of CACHE instructions.
//
// Optional build macro: PIPE_HAZARD_CTRL_PERF_EN
//   When this macro is defined, the block adds two saturating 32-bit
//   counters, stall_cycles and redirect_count, plus their output ports.
//
// Outputs are Mealy outputs: they depend on the current state and on the
// current inputs. No _wr or _flush output feeds back into any input.

module pipe_hazard_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        icache_stall,
    input  logic        dcache_stall,
    input  logic        div_busy,
    input  logic        load_use,
    input  logic        MEM0_exception,
    input  logic        MEM0_is_eret,
    input  logic        MEM0_inst_refetch,
    input  logic        MEM0_cache_op,
    input  logic        cache_op_done,
    output logic        IF_wr,
    output logic        ID_wr,
    output logic        EXE_wr,
    output logic        MEM0_wr,
    output logic        MEM1_wr,
    output logic        ID_flush,
    output logic        EXE_flush,
    output logic        MEM0_flush,
    output logic        MEM1_flush,
    output logic        redirect_valid,
    output logic [1:0]  redirect_sel,
    output logic        cache_op_req
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [31:0] redirect_count
`endif
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_REDIRECT = 2'd1,
        ST_CACHEOP  = 2'd2
    } state_t;

    localparam logic [1:0] SEL_EXC     = 2'b00;
    localparam logic [1:0] SEL_ERET    = 2'b01;
    localparam logic [1:0] SEL_REFETCH = 2'b10;

    state_t      r_state;
    state_t      w_state_next;
    logic [1:0]  r_redirect_sel;
    logic [1:0]  w_redirect_sel_next;

    logic        w_event;
    logic [1:0]  w_event_sel;
    logic        w_event_taken;

    // Any precise MEM0 event. The encoding priority is exception > eret > refetch.
    assign w_event     = MEM0_exception | MEM0_is_eret | MEM0_inst_refetch;
    assign w_event_sel = MEM0_exception ? SEL_EXC :
                         MEM0_is_eret   ? SEL_ERET : SEL_REFETCH;

    // State register and the redirect target latched at the event.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= ST_RUN;
            r_redirect_sel <= SEL_EXC;
        end else begin
            r_state        <= w_state_next;
            r_redirect_sel <= w_redirect_sel_next;
        end
    end

    // Next-state logic and per-stage enables/clears.
    // The rows below are evaluated in priority order.
    always_comb begin
        IF_wr               = 1'b1;
        ID_wr               = 1'b1;
        EXE_wr              = 1'b1;
        MEM0_wr             = 1'b1;
        MEM1_wr             = 1'b1;
        ID_flush            = 1'b0;
        EXE_flush           = 1'b0;
        MEM0_flush          = 1'b0;
        MEM1_flush          = 1'b0;
        redirect_valid      = 1'b0;
        redirect_sel        = SEL_EXC;
        cache_op_req        = 1'b0;
        w_state_next        = r_state;
        w_redirect_sel_next = r_redirect_sel;
        w_event_taken       = 1'b0;

        if (reset) begin
            // Every stage register is cleared while reset is held.
            ID_flush     = 1'b1;
            EXE_flush    = 1'b1;
            MEM0_flush   = 1'b1;
            MEM1_flush   = 1'b1;
            w_state_next = ST_RUN;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (dcache_stall) begin
                        // MEM1 still owns the bus, so the whole pipe freezes.
                        // Events wait in MEM0 until the stall clears.
                        IF_wr   = 1'b0;
                        ID_wr   = 1'b0;
                        EXE_wr  = 1'b0;
                        MEM0_wr = 1'b0;
                        MEM1_wr = 1'b0;
                    end else if (w_event) begin
                        ID_flush   = 1'b1;
                        EXE_flush  = 1'b1;
                        MEM0_flush = 1'b1;
                        // An eret commits through MEM1. The other events
                        // kill the instruction instead.
                        MEM1_flush = (w_event_sel != SEL_ERET);
                        redirect_valid      = 1'b1;
                        redirect_sel        = w_event_sel;
                        w_redirect_sel_next = w_event_sel;
                        w_event_taken       = 1'b1;
                        w_state_next = icache_stall ? ST_REDIRECT : ST_RUN;
                    end else if (MEM0_cache_op) begin
                        IF_wr        = 1'b0;
                        ID_wr        = 1'b0;
                        EXE_wr       = 1'b0;
                        MEM0_wr      = 1'b0;
                        MEM1_flush   = 1'b1;
                        cache_op_req = 1'b1;
                        w_state_next = ST_CACHEOP;
                    end else if (div_busy) begin
                        // Hold IF through EXE, and put a bubble into MEM0.
                        IF_wr      = 1'b0;
                        ID_wr      = 1'b0;
                        EXE_wr     = 1'b0;
                        MEM0_flush = 1'b1;
                    end else if (load_use) begin
                        // Hold the consumer in ID, and put a bubble into EXE.
                        IF_wr     = 1'b0;
                        ID_wr     = 1'b0;
                        EXE_flush = 1'b1;
                    end else if (icache_stall) begin
                        // No fetch this cycle, so ID receives a bubble.
                        IF_wr    = 1'b0;
                        ID_flush = 1'b1;
                    end
                end

                ST_REDIRECT: begin
                    // Hold the redirect request until IF accepts it.
                    redirect_valid = 1'b1;
                    redirect_sel   = r_redirect_sel;
                    ID_flush       = 1'b1;
                    if (!icache_stall) begin
                        w_state_next = ST_RUN;
                    end
                end

                ST_CACHEOP: begin
                    cache_op_req = 1'b1;
                    IF_wr        = 1'b0;
                    ID_wr        = 1'b0;
                    EXE_wr       = 1'b0;
                    if (dcache_stall) begin
                        // A full freeze. A done pulse in this cycle is not taken.
                        MEM0_wr = 1'b0;
                        MEM1_wr = 1'b0;
                    end else if (cache_op_done) begin
                        // Move the finished CACHE instruction on into MEM1.
                        MEM0_flush   = 1'b1;
                        w_state_next = ST_RUN;
                    end else begin
                        MEM0_wr    = 1'b0;
                        MEM1_flush = 1'b1;
                    end
                end

                default: begin
                    w_state_next = ST_RUN;
                end
            endcase
        end
    end

`ifdef PIPE_HAZARD_CTRL_PERF_EN
    logic [31:0] r_stall_cycles;
    logic [31:0] r_redirect_count;

    // Saturating count of front-end stall cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cycles <= 32'd0;
        end else if (!IF_wr && (r_stall_cycles != 32'hFFFF_FFFF)) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

    // Saturating count of the precise events taken in RUN.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_redirect_count <= 32'd0;
        end else if (w_event_taken && (r_redirect_count != 32'hFFFF_FFFF)) begin
            r_redirect_count <= r_redirect_count + 32'd1;
        end
    end

    assign stall_cycles   = r_stall_cycles;
    assign redirect_count = r_redirect_count;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl.
// - A table covers the single-cycle priority rows.
// - Hand-written sequences cover the redirect, cache-op and mid-operation
//   reset cases.
// - Expected outputs are pushed to a queue when a vector is driven.
// - Each entry is popped and compared mid-cycle, on the falling edge.

module tb_pipe_hazard_ctrl;

    logic clk = 1'b0;
    logic reset, icache_stall, dcache_stall, div_busy, load_use;
    logic MEM0_exception, MEM0_is_eret, MEM0_inst_refetch, MEM0_cache_op, cache_op_done;
    logic IF_wr, ID_wr, EXE_wr, MEM0_wr, MEM1_wr;
    logic ID_flush, EXE_flush, MEM0_flush, MEM1_flush;
    logic redirect_valid, cache_op_req;
    logic [1:0] redirect_sel;
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    logic [31:0] stall_cycles, redirect_count;
`endif

    always #5 clk = ~clk;

    pipe_hazard_ctrl dut (
        .clk               (clk),
        .reset             (reset),
        .icache_stall      (icache_stall),
        .dcache_stall      (dcache_stall),
        .div_busy          (div_busy),
        .load_use          (load_use),
        .MEM0_exception    (MEM0_exception),
        .MEM0_is_eret      (MEM0_is_eret),
        .MEM0_inst_refetch (MEM0_inst_refetch),
        .MEM0_cache_op     (MEM0_cache_op),
        .cache_op_done     (cache_op_done),
        .IF_wr             (IF_wr),
        .ID_wr             (ID_wr),
        .EXE_wr            (EXE_wr),
        .MEM0_wr           (MEM0_wr),
        .MEM1_wr           (MEM1_wr),
        .ID_flush          (ID_flush),
        .EXE_flush         (EXE_flush),
        .MEM0_flush        (MEM0_flush),
        .MEM1_flush        (MEM1_flush),
        .redirect_valid    (redirect_valid),
        .redirect_sel      (redirect_sel),
        .cache_op_req      (cache_op_req)
`ifdef PIPE_HAZARD_CTRL_PERF_EN
        ,
        .stall_cycles      (stall_cycles),
        .redirect_count    (redirect_count)
`endif
    );

    // Input bit masks, in the order
    // {reset, icache_stall, dcache_stall, div_busy, load_use,
    //  exception, eret, refetch, cache_op, cache_op_done}.
    localparam logic [9:0] NONE = 10'h000;
    localparam logic [9:0] RST  = 10'h200;
    localparam logic [9:0] IC   = 10'h100;
    localparam logic [9:0] DC   = 10'h080;
    localparam logic [9:0] DIV  = 10'h040;
    localparam logic [9:0] LU   = 10'h020;
    localparam logic [9:0] EXC  = 10'h010;
    localparam logic [9:0] ERET = 10'h008;
    localparam logic [9:0] RF   = 10'h004;
    localparam logic [9:0] COP  = 10'h002;
    localparam logic [9:0] DONE = 10'h001;

    // Expected output layout: {wr[IF,ID,EXE,MEM0,MEM1], flush[ID,EXE,MEM0,MEM1], rv, sel, req}.
    function automatic logic [12:0] ev(input logic [4:0] wr, input logic [3:0] fl,
                                       input logic rv, input logic [1:0] sel, input logic req);
        return {wr, fl, rv, sel, req};
    endfunction

    typedef struct {
        string       name;
        logic [9:0]  stim;
        logic [12:0] exp;
    } vec_t;

    vec_t        tbl[$];
    logic [12:0] exp_q[$];
    string       name_q[$];
    int          checks = 0;
    int          errors = 0;

    task automatic add(input string name, input logic [9:0] stim, input logic [12:0] exp);
        vec_t v;
        v.name = name;
        v.stim = stim;
        v.exp  = exp;
        tbl.push_back(v);
    endtask

    // Drive one cycle of stimulus, queue its expectation, then compare mid-cycle.
    task automatic step(input string name, input logic [9:0] stim, input logic [12:0] exp);
        logic [12:0] act;
        logic [12:0] want;
        string       nm;
        @(posedge clk);
        #1;
        {reset, icache_stall, dcache_stall, div_busy, load_use,
         MEM0_exception, MEM0_is_eret, MEM0_inst_refetch, MEM0_cache_op, cache_op_done} = stim;
        exp_q.push_back(exp);
        name_q.push_back(name);
        @(negedge clk);
        act  = {IF_wr, ID_wr, EXE_wr, MEM0_wr, MEM1_wr, ID_flush, EXE_flush, MEM0_flush,
                MEM1_flush, redirect_valid, redirect_sel, cache_op_req};
        want = exp_q.pop_front();
        nm   = name_q.pop_front();
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got wr=%b fl=%b rv=%b sel=%b req=%b, want wr=%b fl=%b rv=%b sel=%b req=%b",
                     nm, act[12:8], act[7:4], act[3], act[2:1], act[0],
                     want[12:8], want[7:4], want[3], want[2:1], want[0]);
        end else begin
            $display("ok   %s: in=%b wr=%b fl=%b rv=%b sel=%b req=%b",
                     nm, stim, act[12:8], act[7:4], act[3], act[2:1], act[0]);
        end
    endtask

`ifdef PIPE_HAZARD_CTRL_PERF_EN
    task automatic check_cnt(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, act, want);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask
`endif

    initial begin
        {reset, icache_stall, dcache_stall, div_busy, load_use,
         MEM0_exception, MEM0_is_eret, MEM0_inst_refetch, MEM0_cache_op, cache_op_done} = RST;

        // Single-cycle priority rows. Every row leaves the FSM in RUN.
        add("reset0",        RST,            ev(5'b11111, 4'b1111, 0, 2'b00, 0));
        add("reset1",        RST|EXC|IC,     ev(5'b11111, 4'b1111, 0, 2'b00, 0));
        add("idle",          NONE,           ev(5'b11111, 4'b0000, 0, 2'b00, 0));
        add("load_use",      LU,             ev(5'b00111, 4'b0100, 0, 2'b00, 0));
        add("after_lu",      NONE,           ev(5'b11111, 4'b0000, 0, 2'b00, 0));
        add("dcache",        DC,             ev(5'b00000, 4'b0000, 0, 2'b00, 0));
        add("dcache_exc",    DC|EXC|COP,     ev(5'b00000, 4'b0000, 0, 2'b00, 0));
        add("div",           DIV,            ev(5'b00011, 4'b0010, 0, 2'b00, 0));
        add("div_lu",        DIV|LU|IC,      ev(5'b00011, 4'b0010, 0, 2'b00, 0));
        add("lu_ic",         LU|IC,          ev(5'b00111, 4'b0100, 0, 2'b00, 0));
        add("icache",        IC,             ev(5'b01111, 4'b1000, 0, 2'b00, 0));
        add("eret_refetch",  ERET|RF,        ev(5'b11111, 4'b1110, 1, 2'b01, 0));
        add("refetch",       RF,             ev(5'b11111, 4'b1111, 1, 2'b10, 0));
        add("exc_eret_div",  EXC|ERET|DIV,   ev(5'b11111, 4'b1111, 1, 2'b00, 0));
        add("idle2",         NONE,           ev(5'b11111, 4'b0000, 0, 2'b00, 0));

        foreach (tbl[i]) step(tbl[i].name, tbl[i].stim, tbl[i].exp);

        // Exception with icache_stall held for 3 cycles: redirect lasts 4 cycles.
        step("exc_evt",      EXC|IC,  ev(5'b11111, 4'b1111, 1, 2'b00, 0));
        step("redir_c2",     IC,      ev(5'b11111, 4'b1000, 1, 2'b00, 0));
        step("redir_c3",     IC,      ev(5'b11111, 4'b1000, 1, 2'b00, 0));
        step("redir_c4",     NONE,    ev(5'b11111, 4'b1000, 1, 2'b00, 0));
        step("redir_done",   NONE,    ev(5'b11111, 4'b0000, 0, 2'b00, 0));

        // A latched refetch target is held after the event inputs drop.
        step("rf_evt",       RF|IC,   ev(5'b11111, 4'b1111, 1, 2'b10, 0));
        step("rf_hold",      NONE,    ev(5'b11111, 4'b1000, 1, 2'b10, 0));
        step("rf_done",      NONE,    ev(5'b11111, 4'b0000, 0, 2'b00, 0));

        // Cache op. A done pulse in the entry cycle is ignored, and dcache_stall freezes cycle 3.
        step("cop_c1",       COP|DONE, ev(5'b00001, 4'b0001, 0, 2'b00, 1));
        step("cop_c2",       NONE,     ev(5'b00001, 4'b0001, 0, 2'b00, 1));
        step("cop_c3_freeze",DC|DONE,  ev(5'b00000, 4'b0000, 0, 2'b00, 1));
        step("cop_c4_done",  DONE,     ev(5'b00011, 4'b0010, 0, 2'b00, 1));
        step("cop_c5_run",   NONE,     ev(5'b11111, 4'b0000, 0, 2'b00, 0));

        // Reset in the middle of a cache op, and then in the middle of a redirect.
        step("cop_enter",    COP,      ev(5'b00001, 4'b0001, 0, 2'b00, 1));
        step("cop_reset",    RST,      ev(5'b11111, 4'b1111, 0, 2'b00, 0));
        step("cop_after",    NONE,     ev(5'b11111, 4'b0000, 0, 2'b00, 0));
        step("rd_enter",     ERET|IC,  ev(5'b11111, 4'b1110, 1, 2'b01, 0));
        step("rd_reset",     RST|IC,   ev(5'b11111, 4'b1111, 0, 2'b00, 0));
        step("rd_after",     IC,       ev(5'b01111, 4'b1000, 0, 2'b00, 0));

`ifdef PIPE_HAZARD_CTRL_PERF_EN
        step("perf_reset",   RST,      ev(5'b11111, 4'b1111, 0, 2'b00, 0));
        for (int k = 0; k < 5; k++)
            step("perf_lu",  LU,       ev(5'b00111, 4'b0100, 0, 2'b00, 0));
        step("perf_exc",     EXC,      ev(5'b11111, 4'b1111, 1, 2'b00, 0));
        step("perf_idle",    NONE,     ev(5'b11111, 4'b0000, 0, 2'b00, 0));
        check_cnt("stall_cycles", stall_cycles, 32'd5);
        check_cnt("redirect_count", redirect_count, 32'd1);
        force dut.r_stall_cycles = 32'hFFFF_FFFF;
        step("perf_sat_lu",  LU,       ev(5'b00111, 4'b0100, 0, 2'b00, 0));
        release dut.r_stall_cycles;
        step("perf_sat_lu2", LU,       ev(5'b00111, 4'b0100, 0, 2'b00, 0));
        step("perf_sat_idle",NONE,     ev(5'b11111, 4'b0000, 0, 2'b00, 0));
        check_cnt("stall_sat", stall_cycles, 32'hFFFF_FFFF);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
